uart_word_tx: RTL

- UART transmitter for the CPU core's output path, paired with the loader receiver on UART_RX.
- Accepts 32-bit words or single bytes from the core's print/output logic through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each entry onto UART_TX as 8N1 frames. Word entries go out most-significant byte first, the same byte order the host uses when it loads instructions.
- Sits between the CPU execution stage and the board TX pin.

---
 rtl/cpu_uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_word_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_uart_pkg.sv
// Shared UART definitions for the CPU core's serial path.
//   T          - clock cycles per UART bit (shared with the loader receiver)
//   FRAME_BITS - bits per 8N1 frame (start + 8 data + stop)
//   tx_state_t - serializer states
//   sel_byte   - picks byte idx of a word, idx 0 = [31:24] (host load order)
package cpu_uart_pkg;

  localparam int unsigned T          = 2604;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding transmit entries.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, wdata   - write request (ignored when full) and entry data
//   pop, rdata    - read request (ignored when empty); rdata shows the head
//   full, empty   - derived from level
//   level         - current occupancy, 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible through level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_word_tx.sv
// UART transmitter for the CPU output path: buffers words/bytes in a FIFO
// and sends them as 8N1 frames, words most-significant byte first.
// Ports:
//   CLK, RST_N         - clock, asynchronous active-low reset
//   IN_VALID/IN_READY  - entry handshake, transfer when both high at CLK
//   IN_DATA, IN_WORD   - payload; IN_WORD=1 sends 4 bytes, 0 sends [7:0]
//   UART_TX            - serial line, idle high, driven from a flop
//   BUSY               - FIFO non-empty or frame in progress
//   LEVEL              - FIFO occupancy
module uart_word_tx import cpu_uart_pkg::*; #(
  parameter int unsigned T     = cpu_uart_pkg::T,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [31:0]   IN_DATA,
  input  logic          IN_WORD,
  output logic          UART_TX,
  output logic          BUSY,
  output logic [AW:0]   LEVEL
);

  localparam int unsigned CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(T - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          tx_q, tx_d;
  logic          rdy_en_q;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [32:0]   fifo_head;
  logic [7:0]    cur_byte;
  logic          baud_end;

  // IN_READY is built only from flops, so IN_VALID never feeds back into it.
  assign IN_READY  = rdy_en_q && !fifo_full;
  assign fifo_push = IN_VALID && IN_READY;
  assign UART_TX   = tx_q;
  assign BUSY      = (LEVEL != '0) || (state_q != IDLE);
  assign cur_byte  = sel_byte(word_q, idx_q);
  assign baud_end  = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (33)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .wdata ({IN_WORD, IN_DATA}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    word_d   = word_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_head[31:0];
          idx_d    = fifo_head[32] ? 2'd0 : 2'd3;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames have no gap.
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            tx_d    = 1'b0;
            state_d = START;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            word_d   = fifo_head[31:0];
            idx_d    = fifo_head[32] ? 2'd0 : 2'd3;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      tx_q     <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      tx_q     <= tx_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
